servo_instr_sequencer: RTL and testbench
========================================

# servo_instr_sequencer

Controller that sequences the serial instruction receiver and dispatches each received 10-bit instruction to one of four servo position registers. It sits between the mbed-facing receiver and the PWM generators. It clears the receiver between frames, watches for stalled frames, clamps positions, and counts aborted frames.

## Interface
Parameters:
- CLEAR_CYCLES, 4: cycles rx_clear is held high per clear; must be ≥1.
- TIMEOUT_CYCLES, 50000: cycles without receiver state change before a started frame is aborted.
- POS_MIN, 8'd16: lowest legal position.
- POS_MAX, 8'd240: highest legal position.
- POS_RESET, 8'd128: position value after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- enable  in  1  1 = accept completed instructions; 0 = hold them in the receiver.
- instr_ready  in  1  receiver frame-complete flag; level-held until the receiver is cleared.
- instr  in  10  received word: [9:8] = channel, [7:0] = raw position.
- rx_state  in  2  receiver state: 0 counting, 1 receive, 2 confirmed, 3 complete.
- rx_clear  out  1  active-high clear to the receiver's reset input.
- pos0, pos1, pos2, pos3  out  8 each  servo position registers.
- chan_update  out  4  one-cycle pulse; bit k means posk changed this cycle.
- error_count  out  8  aborted-frame count; saturates at 255.

## Operation
Reset (reset=0 at an edge), effective on the next edge:
- state=CLEAR, clear counter=0, rx_clear=1.
- pos0..pos3=POS_RESET, chan_update=0, error_count=0, frame_active=0, timeout counter=0.
- Reset asserted mid-operation aborts any latched instruction; no position write occurs.

States:
- CLEAR:
  - rx_clear=1 while in this state.
  - The clear counter counts 0..CLEAR_CYCLES-1, then the state goes to WAIT.
  - frame_active and the timeout counter are cleared.
- WAIT:
  - rx_clear=0.
  - frame_active sets when rx_state≠0 is sampled.
  - While frame_active, the timeout counter increments each cycle. It reloads to 0 whenever rx_state differs from its value on the previous cycle.
  - instr_ready=1 and enable=1 → LATCH.
  - instr_ready=1 and enable=0 → stay in WAIT. The timeout counter is frozen (no abort while held).
  - Timeout counter reaches TIMEOUT_CYCLES-1 with instr_ready=0 → ERR.
  - instr_ready and timeout in the same cycle: instr_ready wins (LATCH, or hold if enable=0).
- LATCH:
  - Capture instr into an internal register.
  - Clamp the position: value<POS_MIN → POS_MIN; value>POS_MAX → POS_MAX; otherwise unchanged.
  - → APPLY.
- APPLY:
  - Write the clamped value to pos[channel].
  - Set chan_update to a one-hot of channel.
  - → CLEAR.
  - The write and pulse occur even if the new value equals the old value.
- ERR:
  - error_count += 1, saturating at 255 (255 stays 255).
  - → CLEAR. No position change.

General rules:
- chan_update is 0 in every cycle except the one following APPLY.
- instr_ready outside WAIT is ignored.
- Positions change only through APPLY.

## Timing
- All outputs are registered.
- Edge E0 samples instr_ready=1 (enable=1) in WAIT.
- E1: instruction latched.
- E2:
  - pos[channel] holds the new value.
  - chan_update bit is high for the cycle E2–E3.
  - rx_clear goes high.
- rx_clear stays high for exactly CLEAR_CYCLES cycles, then drops; WAIT is resumed.
- Frame-to-frame overhead is 2 + CLEAR_CYCLES cycles beyond the receiver time.
- After reset is released, rx_clear stays high for CLEAR_CYCLES cycles before the first WAIT.
- Abort: the last rx_state change, plus TIMEOUT_CYCLES cycles, gives entry to ERR. error_count increments at the following edge, then CLEAR follows.

## Test plan
- Reset, then release → pos0..3=128, error_count=0, chan_update=0, rx_clear high 4 cycles then low.
- instr=10'b10_0110_0100 (ch2, 100), instr_ready=1, enable=1 → pos2=100 two edges later, chan_update=4'b0100 for one cycle, rx_clear high for 4 cycles, pos0/1/3 unchanged.
- instr=ch0 raw 5, then ch3 raw 250 → pos0=16, pos3=240 (clamped); each produces one chan_update pulse.
- rx_state moves 0→1 and then freezes (TIMEOUT_CYCLES=20 for sim) → ERR after 20 cycles, error_count=1, rx_clear pulse, no pos change. Repeat 256 times → error_count stays 255.
- enable=0 with instr_ready=1 for 100 cycles, exceeding the timeout → no abort, no update. Set enable=1 → update proceeds normally.
- reset=0 asserted during LATCH → next edge gives CLEAR, positions=128, chan_update never pulses. instr_ready and timeout coinciding → LATCH taken, error_count unchanged.

Source files
------------

// File: rtl/servo_instr_sequencer.sv
// Servo instruction sequencer: clears the serial receiver between frames, dispatches
// each completed 10-bit instruction to one of four clamped position registers.

module servo_pos_reg #(
    parameter logic [7:0] POS_RESET = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] pos,
    output logic       upd
);
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos <= POS_RESET;
            upd <= 1'b0;
        end else begin
            upd <= wr;
            if (wr) pos <= din;
        end
    end
endmodule

module servo_instr_sequencer #(
    parameter int         CLEAR_CYCLES   = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] POS_MIN        = 8'd16,
    parameter logic [7:0] POS_MAX        = 8'd240,
    parameter logic [7:0] POS_RESET      = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       instr_ready,
    input  logic [9:0] instr,
    input  logic [1:0] rx_state,
    output logic       rx_clear,
    output logic [7:0] pos0,
    output logic [7:0] pos1,
    output logic [7:0] pos2,
    output logic [7:0] pos3,
    output logic [3:0] chan_update,
    output logic [7:0] error_count
);
    localparam int NUM_CH = 4;
    localparam int CW     = $clog2(CLEAR_CYCLES + 1);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_CLEAR, S_WAIT, S_LATCH, S_APPLY, S_ERR} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            clr_cnt;
    logic [TW-1:0]            tcnt;
    logic                     frame_active;
    logic [1:0]               prev_rx;
    logic [1:0]               lat_ch;
    logic [7:0]               lat_pos;
    logic [7:0]               clamped;
    logic [NUM_CH-1:0]        wr;
    logic [NUM_CH-1:0]        upd;
    logic [NUM_CH-1:0][7:0]   pos_q;

    always_comb begin
        clamped = instr[7:0];
        if (instr[7:0] < POS_MIN)      clamped = POS_MIN;
        else if (instr[7:0] > POS_MAX) clamped = POS_MAX;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_CLEAR;
        else        state <= state_nxt;
    end

    // A completed frame beats a coincident timeout; a held frame never aborts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                if (instr_ready) begin
                    if (enable) state_nxt = S_LATCH;
                end else if (frame_active && tcnt == TO_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_LATCH: state_nxt = S_APPLY;
            S_APPLY: state_nxt = S_CLEAR;
            S_ERR:   state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_cnt      <= '0;
            tcnt         <= '0;
            frame_active <= 1'b0;
            prev_rx      <= 2'd0;
            rx_clear     <= 1'b1;
            error_count  <= 8'd0;
            lat_ch       <= 2'd0;
            lat_pos      <= 8'd0;
        end else begin
            rx_clear <= (state_nxt == S_CLEAR);
            prev_rx  <= rx_state;
            case (state)
                S_CLEAR: begin
                    clr_cnt      <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + CW'(1);
                    frame_active <= 1'b0;
                    tcnt         <= '0;
                end
                S_WAIT: begin
                    if (!instr_ready) begin
                        if (rx_state != 2'd0) frame_active <= 1'b1;
                        if (rx_state != prev_rx)  tcnt <= '0;
                        else if (frame_active)    tcnt <= tcnt + TW'(1);
                    end
                end
                S_LATCH: begin
                    lat_ch  <= instr[9:8];
                    lat_pos <= clamped;
                end
                S_ERR: if (error_count != 8'hFF) error_count <= error_count + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        wr = '0;
        if (state == S_APPLY) wr[lat_ch] = 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_pos_reg #(.POS_RESET(POS_RESET)) u_pos (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[g]),
            .din   (lat_pos),
            .pos   (pos_q[g]),
            .upd   (upd[g])
        );
    end

    assign chan_update = upd;
    assign pos0 = pos_q[0];
    assign pos1 = pos_q[1];
    assign pos2 = pos_q[2];
    assign pos3 = pos_q[3];
endmodule

// File: tb/tb_servo_instr_sequencer.sv
// Scoreboard bench for servo_instr_sequencer: expected updates queued at drive time,
// popped when chan_update pulses.

module tb_servo_instr_sequencer;
    localparam int CLEAR_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       instr_ready = 1'b0;
    logic [9:0] instr = '0;
    logic [1:0] rx_state = 2'd0;
    logic       rx_clear;
    logic [7:0] pos0, pos1, pos2, pos3;
    logic [3:0] chan_update;
    logic [7:0] error_count;

    servo_instr_sequencer #(
        .CLEAR_CYCLES   (CLEAR_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .POS_MIN        (8'd16),
        .POS_MAX        (8'd240),
        .POS_RESET      (8'd128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rx_state    (rx_state),
        .rx_clear    (rx_clear),
        .pos0        (pos0),
        .pos1        (pos1),
        .pos2        (pos2),
        .pos3        (pos3),
        .chan_update (chan_update),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int pos;
    } exp_t;

    exp_t       sbq[$];
    int         exp_pos[4] = '{128, 128, 128, 128};
    int         exp_err = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] pos_v[4];

    assign pos_v[0] = pos0;
    assign pos_v[1] = pos1;
    assign pos_v[2] = pos2;
    assign pos_v[3] = pos3;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int raw);
        if (raw < 16)  return 16;
        if (raw > 240) return 240;
        return raw;
    endfunction

    // Scoreboard: every pulse must match the oldest queued instruction.
    always @(negedge clk) begin : mon
        exp_t e;
        if (chan_update != 4'd0) begin
            if (sbq.size() == 0) begin
                chk("spurious_upd", int'(chan_update), 0);
            end else begin
                e = sbq.pop_front();
                chk("upd_onehot", int'(chan_update), 1 << e.ch);
                exp_pos[e.ch] = e.pos;
                for (int k = 0; k < 4; k++) chk($sformatf("pos%0d", k), int'(pos_v[k]), exp_pos[k]);
            end
        end
    end

    task automatic chk_all_pos(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_pos%0d", tag, k), int'(pos_v[k]), exp_pos[k]);
    endtask

    task automatic chk_clr_len();
        int cnt = 0;
        while (rx_clear && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("clr_len", cnt, CLEAR_CYCLES);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rx_clear && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("idle_timeout", int'(rx_clear), 0);
    endtask

    task automatic wait_upd();
        int  lat = 0;
        bit  got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (chan_update != 4'd0) got = 1;
        end
        chk("upd_latency", got ? lat : -1, 3);
        instr_ready = 1'b0;
        rx_state    = 2'd0;
        chk_clr_len();
    endtask

    task automatic send(input int ch, input int raw);
        wait_idle();
        instr       = 10'(ch * 256 + raw);
        instr_ready = 1'b1;
        enable      = 1'b1;
        sbq.push_back('{ch, clamp(raw)});
        wait_upd();
    endtask

    task automatic abort_frame(output int lat);
        wait_idle();
        rx_state = 2'd1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rx_clear && lat < 100);
        rx_state = 2'd0;
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;

        // reset state
        repeat (3) @(negedge clk);
        chk_all_pos("rst");
        chk("rst_err", int'(error_count), 0);
        chk("rst_upd", int'(chan_update), 0);
        chk("rst_clr", int'(rx_clear), 1);
        reset = 1'b1;
        chk_clr_len();

        // plain dispatch and clamping at both ends
        send(2, 100);
        send(0, 5);
        send(3, 250);
        send(1, 16);
        send(1, 240);
        send(0, 241);
        chk_all_pos("after_sends");

        // stalled frame aborts
        abort_frame(lat);
        chk("abort_lat", lat, TIMEOUT_CYCLES + 2);
        exp_err = 1;
        chk("abort_err", int'(error_count), exp_err);
        chk_all_pos("abort");
        chk_clr_len();

        // held instruction must neither abort nor update
        wait_idle();
        rx_state = 2'd1;
        repeat (3) @(negedge clk);
        rx_state    = 2'd3;
        instr       = {2'd1, 8'd77};
        instr_ready = 1'b1;
        enable      = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rx_clear || chan_update != 4'd0) bad++;
        end
        chk("hold_quiet", bad, 0);
        chk("hold_err", int'(error_count), exp_err);
        enable = 1'b1;
        sbq.push_back('{1, 77});
        wait_upd();

        // reset lands while the instruction is in LATCH
        wait_idle();
        instr       = {2'd3, 8'd200};
        instr_ready = 1'b1;
        enable      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_pos = '{128, 128, 128, 128};
        exp_err = 0;
        chk_all_pos("latch_rst");
        chk("latch_rst_clr", int'(rx_clear), 1);
        chk("latch_rst_upd", int'(chan_update), 0);
        chk("latch_rst_err", int'(error_count), 0);
        reset       = 1'b1;
        instr_ready = 1'b0;
        chk_clr_len();
        repeat (5) @(negedge clk);
        chk_all_pos("latch_rst_later");

        // ready and timeout in the same cycle: ready wins
        wait_idle();
        rx_state = 2'd1;
        repeat (TIMEOUT_CYCLES) @(negedge clk);
        instr       = {2'd1, 8'd60};
        instr_ready = 1'b1;
        enable      = 1'b1;
        sbq.push_back('{1, 60});
        wait_upd();
        chk("coincide_err", int'(error_count), exp_err);

        // error counter saturation
        for (int i = 0; i < 256; i++) begin
            abort_frame(lat);
            if (i < 2) chk("sat_lat", lat, TIMEOUT_CYCLES + 2);
            if (i == 254) chk("err_255", int'(error_count), 255);
        end
        chk("err_sat", int'(error_count), 255);
        chk_all_pos("sat");
        chk_clr_len();

        send(2, 0);
        chk("sbq_empty", sbq.size(), 0);
        chk_all_pos("final");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
